// File: rtl/best_arr_stream.sv
// Drains the best-match array through a small FIFO. Each 64-bit entry leaves as two 32-bit
// words, lower half first. Define BEST_ARR_STREAM_CHKSUM_EN to enable the XOR checksum on chksum_o.
module best_arr_stream #(
    parameter int NUM_ENTRIES = 256,
    parameter int ADDRW       = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    output logic             best_arr_csb1,
    output logic [ADDRW-1:0] best_arr_addr1,
    input  logic [63:0]      best_arr_rdata1,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [31:0]      rd_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      chksum_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t       state;
    logic [ADDRW:0] issue_ptr;
    logic         inflight;
    logic [63:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic         upper;
    logic         issue, hs, pop, start_ok;

    // A read is issued only when the FIFO has room for it plus whatever is already in flight.
    assign issue = (state == RUN) && (32'(issue_ptr) < NUM_ENTRIES) &&
                   ((32'(count) + 32'(inflight)) < FIFO_DEPTH);
    assign best_arr_csb1  = ~issue;
    assign best_arr_addr1 = issue_ptr[ADDRW-1:0];

    assign rd_valid_o = (count != '0);
    assign hs         = rd_valid_o & rd_ready_i;
    assign pop        = hs & upper;
    assign start_ok   = start_i & ((state == IDLE) || (state == DONE));
    assign rd_data_o  = !rd_valid_o ? 32'h0 :
                        upper ? mem[rd_ptr][63:32] : mem[rd_ptr][31:0];

    always_ff @(posedge wb_clk_i) begin
        if (inflight)
            mem[wr_ptr] <= best_arr_rdata1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            issue_ptr <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            upper     <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue)
                issue_ptr <= issue_ptr + 1'b1;
            if (inflight)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (hs)
                upper <= ~upper;
            count <= count + CW'(inflight) - CW'(pop);

            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state     <= RUN;
                        issue_ptr <= '0;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        count     <= '0;
                        upper     <= 1'b0;
                        busy_o    <= 1'b1;
                        done_o    <= 1'b0;
                    end
                end
                RUN: begin
                    if ((32'(issue_ptr) == NUM_ENTRIES) && !inflight)
                        state <= FLUSH;
                end
                FLUSH: begin
                    if (count == '0) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BEST_ARR_STREAM_CHKSUM_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || start_ok)
            chksum_o <= 32'h0;
        else if (hs)
            chksum_o <= chksum_o ^ rd_data_o;
    end
`else
    assign chksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_best_arr_stream.sv
// Scoreboard bench for best_arr_stream: a 4-entry and a 256-entry instance run side by side
// on shared start/ready/reset, each fed by a best-array model.
module tb_best_arr_stream;
    logic clk = 1'b0;
    logic rst, start, ready;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        csb4, csb256, valid4, valid256, busy4, busy256, done4, done256;
    logic [7:0]  addr4, addr256;
    logic [63:0] rdata4, rdata256;
    logic [31:0] data4, data256, chk4, chk256;

    best_arr_stream #(.NUM_ENTRIES(4), .ADDRW(8), .FIFO_DEPTH(4)) u4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .best_arr_csb1(csb4), .best_arr_addr1(addr4), .best_arr_rdata1(rdata4),
        .rd_valid_o(valid4), .rd_ready_i(ready), .rd_data_o(data4),
        .busy_o(busy4), .done_o(done4), .chksum_o(chk4));

    best_arr_stream #(.NUM_ENTRIES(256), .ADDRW(8), .FIFO_DEPTH(4)) u256 (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .best_arr_csb1(csb256), .best_arr_addr1(addr256), .best_arr_rdata1(rdata256),
        .rd_valid_o(valid256), .rd_ready_i(ready), .rd_data_o(data256),
        .busy_o(busy256), .done_o(done256), .chksum_o(chk256));

    function automatic logic [63:0] entry(input logic [7:0] a);
        return {24'h0, a, 16'hDEAD, 8'h00, a};
    endfunction

    always @(posedge clk) if (!csb4)   rdata4   <= entry(addr4);
    always @(posedge clk) if (!csb256) rdata256 <= entry(addr256);

    int checks = 0, errors = 0;
    logic [31:0] q4[$], q256[$];
    logic [31:0] x4 = 0, x256 = 0;
    int rc4 = 0, rc256 = 0, lp4 = 0, lp256 = 0;
    logic dp4 = 0, dp256 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) rc4 = 0;
        else begin
            if (!csb4) begin chk("addr4", 64'(addr4), 64'(rc4)); rc4++; end
            if (valid4 && ready) begin
                if (q4.size() == 0) chk("extra4", 1, 0);
                else chk("data4", 64'(data4), 64'(q4.pop_front()));
                lp4 = cyc;
            end
            if (done4 && !dp4) chk("done_lat4", 64'(cyc - lp4), 2);
        end
        dp4 = done4;
    end

    always @(negedge clk) begin
        if (rst) rc256 = 0;
        else begin
            if (!csb256) begin chk("addr256", 64'(addr256), 64'(rc256)); rc256++; end
            if (valid256 && ready) begin
                if (q256.size() == 0) chk("extra256", 1, 0);
                else chk("data256", 64'(data256), 64'(q256.pop_front()));
                lp256 = cyc;
            end
            if (done256 && !dp256) chk("done_lat256", 64'(cyc - lp256), 2);
        end
        dp256 = done256;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_drain();
        logic [63:0] e;
        q4.delete(); q256.delete(); x4 = 0; x256 = 0; rc4 = 0; rc256 = 0;
        for (int a = 0; a < 4; a++) begin
            e = entry(8'(a));
            q4.push_back(e[31:0]); q4.push_back(e[63:32]); x4 = x4 ^ e[31:0] ^ e[63:32];
        end
        for (int a = 0; a < 256; a++) begin
            e = entry(8'(a));
            q256.push_back(e[31:0]); q256.push_back(e[63:32]); x256 = x256 ^ e[31:0] ^ e[63:32];
        end
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_csb4"}, 64'(csb4), 1);     chk({tag, "_csb256"}, 64'(csb256), 1);
        chk({tag, "_addr4"}, 64'(addr4), 0);   chk({tag, "_addr256"}, 64'(addr256), 0);
        chk({tag, "_vld4"}, 64'(valid4), 0);   chk({tag, "_vld256"}, 64'(valid256), 0);
        chk({tag, "_data4"}, 64'(data4), 0);   chk({tag, "_data256"}, 64'(data256), 0);
        chk({tag, "_busy4"}, 64'(busy4), 0);   chk({tag, "_busy256"}, 64'(busy256), 0);
        chk({tag, "_done4"}, 64'(done4), 0);   chk({tag, "_done256"}, 64'(done256), 0);
        chk({tag, "_sum4"}, 64'(chk4), 0);     chk({tag, "_sum256"}, 64'(chk256), 0);
    endtask

    task automatic wait_done(input string tag, input bit alt);
        int n = 0;
        while (!(done4 && done256) && n < 4000) begin
            if (alt) ready = ~ready;
            step(); n++;
        end
        ready = 1'b1;
        chk({tag, "_timeout"}, 64'(n < 4000), 1);
        chk({tag, "_busy4"}, 64'(busy4), 0);
        chk({tag, "_busy256"}, 64'(busy256), 0);
        chk({tag, "_sb4"}, 64'(q4.size()), 0);
        chk({tag, "_sb256"}, 64'(q256.size()), 0);
`ifdef BEST_ARR_STREAM_CHKSUM_EN
        chk({tag, "_sum4"}, 64'(chk4), 64'(x4));
        chk({tag, "_sum256"}, 64'(chk256), 64'(x256));
`else
        chk({tag, "_sum4"}, 64'(chk4), 0);
        chk({tag, "_sum256"}, 64'(chk256), 0);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        repeat (3) step();
        chk_rst("reset");
        rst = 1'b0;
        repeat (6) step();

        // full rate with first-read latency
        start_drain();
        chk("lat_csb4", 64'(csb4), 0);     chk("lat_addr4", 64'(addr4), 0);
        chk("lat_csb256", 64'(csb256), 0);
        step();
        chk("lat_vld_n2", 64'(valid4), 0);
        step();
        chk("lat_vld_n3", 64'(valid4), 1);
        chk("lat_data_n3", 64'(data4), 64'h0000_0000_DEAD_0000);
        wait_done("full", 1'b0);
        chk("full_done4", 64'(done4), 1);

        // backpressure: only FIFO_DEPTH reads may go out
        ready = 1'b0;
        start_drain();
        repeat (19) step();
        chk("bp_reads4", 64'(rc4), 4);     chk("bp_reads256", 64'(rc256), 4);
        chk("bp_csb256", 64'(csb256), 1);  chk("bp_vld256", 64'(valid256), 1);
        chk("bp_data4", 64'(data4), 64'h0000_0000_DEAD_0000);
        chk("bp_data256", 64'(data256), 64'h0000_0000_DEAD_0000);
        ready = 1'b1;
        wait_done("bp", 1'b0);

        // alternating ready
        ready = 1'b0;
        start_drain();
        wait_done("alt", 1'b1);

        // start while busy ignored, then reset mid-drain
        start_drain();
        repeat (4) step();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk_rst("midrst");
        q4.delete(); q256.delete();
        step();
        start_drain();
        wait_done("fresh", 1'b0);

        // restart from DONE
        start_drain();
        wait_done("again", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/best_arr_stream.md
Name: best_arr_stream

Overview:
- Drains the best-match array after a search completes and turns each 64-bit entry into two 32-bit words on a valid/ready stream.
- Sits downstream of the best array, on its port 1 (read-only, csb1/addr1/rdata1), and upstream of the Wishbone read path in wbsCtrl.
- The host pops words from one streaming register instead of doing two address-decoded reads per entry.

Parameters:
NUM_ENTRIES, 256, number of best-array entries to drain (addresses 0..NUM_ENTRIES-1)
ADDRW, 8, best-array address width; NUM_ENTRIES <= 2**ADDRW
FIFO_DEPTH, 4, 64-bit entries buffered internally; power of two, minimum 2

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset
start_i  in  1  single-cycle pulse that starts a drain of addresses 0..NUM_ENTRIES-1
best_arr_csb1  out  1  best-array port-1 chip select, active low
best_arr_addr1  out  ADDRW  best-array read address
best_arr_rdata1  in  64  read data, valid the cycle after csb1=0
rd_valid_o  out  1  output word available
rd_ready_i  in  1  consumer accepts word
rd_data_o  out  32  output word
busy_o  out  1  drain in progress
done_o  out  1  drain finished, all words consumed
chksum_o  out  32  running XOR of popped words (see Optional Feature)

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. Clock port wb_clk_i, reset port wb_rst_i.
- Reset values:
  - best_arr_csb1=1, best_arr_addr1=0.
  - rd_valid_o=0, rd_data_o=0, busy_o=0, done_o=0, chksum_o=0.
  - FIFO empty, half-select=lower, state=IDLE.
- Reset mid-drain: aborts the drain and returns to reset values on the next edge; any in-flight read data is discarded.
- States:
  - IDLE: start_i → RUN. Clear issue_ptr, FIFO, half-select and chksum; set busy_o=1, done_o=0.
  - RUN: issue a read (csb1=0, addr1=issue_ptr, issue_ptr+1) in any cycle where issue_ptr<NUM_ENTRIES and fifo_count+inflight<FIFO_DEPTH.
    - inflight is 1 in the cycle after a read is issued.
    - best_arr_rdata1 is pushed into the FIFO in that cycle.
    - When issue_ptr==NUM_ENTRIES and inflight==0 → FLUSH.
  - FLUSH: no reads. When the FIFO is empty → DONE.
  - DONE: busy_o=0, done_o=1 (held). start_i → RUN with the same clearing as from IDLE.
- start_i while busy_o=1 is ignored.
- Reads go out back-to-back whenever credit allows. The credit rule guarantees no FIFO overflow; data is never dropped and no read is reissued.
- Output stream:
  - rd_valid_o=1 iff the FIFO is non-empty.
  - rd_data_o = head[31:0] when half-select=lower, head[63:32] when half-select=upper. Data is combinational from the FIFO head and registered half-select.
  - Handshake when rd_valid_o & rd_ready_i. If lower: half-select→upper. If upper: pop the head and set half-select→lower.
  - rd_data_o is stable while rd_valid_o=1 and rd_ready_i=0.
- Simultaneous push and pop in the same cycle: both take effect; fifo_count is unchanged.
- First-read latency: start_i at cycle N → csb1=0 at N+1 → rd_valid_o=1 at N+3.
- Full-rate consumption (rd_ready_i=1) sustains 2 words per entry. Reads throttle to one every 2 cycles once FIFO credit is exhausted.
- Pointers wrap modulo FIFO_DEPTH. issue_ptr saturates at NUM_ENTRIES.

Optional Feature:
- Macro BEST_ARR_STREAM_CHKSUM_EN.
- Defined:
  - chksum_o ^= rd_data_o on every handshake.
  - Cleared on start_i (accepted) and on reset.
  - Holds its value in DONE.
- Undefined: chksum_o is tied to 0 and no checksum logic is synthesised.

Test Plan:
- Entry addr a returns {24'h0, a, 32'hDEAD_0000|a}; NUM_ENTRIES=4; start_i pulse; rd_ready_i=1.
  - Words in order DEAD_0000, 0000_0000, DEAD_0001, 0000_0001, …, DEAD_0003, 0000_0003.
  - done_o=1 two cycles after the last pop; busy_o=0.
  - chksum_o = XOR of the 8 words when the macro is defined, else 0.
- Latency: same memory model; start_i at cycle 10 → csb1=0, addr1=0 at cycle 11; rd_valid_o=1 at cycle 13.
- Backpressure: rd_ready_i=0 for 20 cycles after start.
  - Exactly FIFO_DEPTH=4 reads issued; csb1 stays 1 afterwards.
  - rd_data_o stays at DEAD_0000.
  - Releasing rd_ready_i delivers all words with none lost or duplicated.
- Alternating rd_ready_i (1,0,1,0…) with NUM_ENTRIES=256 → 512 words, in address order, each upper word following its lower.
- start_i asserted again at cycle 5 of a drain → ignored, issue_ptr continues. wb_rst_i at cycle 8 → all outputs at reset values at cycle 9; a fresh start_i then drains from address 0.
- start_i in DONE → second full drain with identical data; chksum_o restarts from 0.
